baud_frac_gen: RTL and testbench

Programmable fractional baud-rate generator for the UART, and the parametrised successor of the fixed mod-M rate generator. It divides the system clock by a runtime-loadable integer-plus-fraction divisor to produce an oversampling tick for the receiver. It also divides that tick by a fixed oversampling ratio to produce a per-bit tick for the transmitter. Divisor changes take effect only at period boundaries, so no tick period is ever truncated.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/os_counter.sv | 31 +++
 rtl/baud_frac_gen.sv | 120 ++++++++++++
 tb/tb_baud_frac_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: default widths, oversampling ratio and
// integer/fraction divisor presets for a 50 MHz system clock.
package uart_pkg;

  localparam int UART_DIV_W      = 16;
  localparam int UART_FRAC_W     = 4;
  localparam int UART_OVERSAMPLE = 16;

  typedef struct packed {
    logic [15:0] div_int;
    logic [3:0]  div_frac;
  } baud_preset_t;

  typedef enum logic [1:0] {
    BAUD_SEL_9600   = 2'd0,
    BAUD_SEL_19200  = 2'd1,
    BAUD_SEL_115200 = 2'd2
  } baud_sel_e;

  localparam baud_preset_t BAUD_9600   = '{div_int: 16'd325, div_frac: 4'd8};
  localparam baud_preset_t BAUD_19200  = '{div_int: 16'd162, div_frac: 4'd12};
  localparam baud_preset_t BAUD_115200 = '{div_int: 16'd27,  div_frac: 4'd2};

  function automatic baud_preset_t baud_preset(input baud_sel_e sel);
    baud_preset_t p;
    case (sel)
      BAUD_SEL_9600:   p = BAUD_9600;
      BAUD_SEL_19200:  p = BAUD_19200;
      BAUD_SEL_115200: p = BAUD_115200;
      default:         p = BAUD_115200;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/os_counter.sv
// Mod-OVERSAMPLE phase counter; wrap marks the last phase so the
// caller can turn the matching oversample tick into a bit tick.
module os_counter #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] cnt_r;

  // Phase register: clear wins over advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= (cnt_r == LAST) ? '0 : cnt_r + CNT_W'(1);
    end
  end

  assign wrap = (cnt_r == LAST);

endmodule

// File: rtl/baud_frac_gen.sv
// Fractional baud-rate generator: oversample tick from an integer+fraction
// divisor, bit tick every OVERSAMPLE ticks, divisor swaps only at boundaries.
module baud_frac_gen
  import uart_pkg::*;
#(
  parameter int DIV_W        = UART_DIV_W,
  parameter int FRAC_W       = UART_FRAC_W,
  parameter int OVERSAMPLE   = UART_OVERSAMPLE,
  parameter int DEFAULT_DIV  = int'(BAUD_115200.div_int),
  parameter int DEFAULT_FRAC = int'(BAUD_115200.div_frac)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              pend,
  output logic              tick_os,
  output logic              tick_bit,
  output logic [DIV_W-1:0]  q
);

  localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(DEFAULT_DIV);
  localparam logic [FRAC_W-1:0] FRAC_RST = FRAC_W'(DEFAULT_FRAC);

  logic [DIV_W-1:0]  cnt_r;
  logic [DIV_W-1:0]  div_r;
  logic [DIV_W-1:0]  pdiv_r;
  logic [FRAC_W-1:0] acc_r;
  logic [FRAC_W-1:0] frac_r;
  logic [FRAC_W-1:0] pfrac_r;
  logic              c_r;
  logic              pend_r;

  logic [DIV_W:0]    len_s;
  logic [DIV_W:0]    last_s;
  logic [FRAC_W:0]   sum_s;
  logic [DIV_W-1:0]  load_div_s;
  logic              tick_os_s;
  logic              apply_s;
  logic              wrap_s;

  // Period is one cycle longer whenever the fraction accumulator carried.
  assign len_s     = {1'b0, div_r} + {{DIV_W{1'b0}}, c_r};
  assign last_s    = len_s - (DIV_W + 1)'(1);
  assign sum_s     = {1'b0, acc_r} + {1'b0, frac_r};
  assign tick_os_s = en & ~restart & ({1'b0, cnt_r} == last_s);
  assign apply_s   = pend_r & (tick_os_s | ~en);

  // A zero divisor would never reach a boundary, so clamp it to one.
  always_comb begin
    load_div_s = div_int;
    if (div_int == '0) begin
      load_div_s = DIV_W'(1);
    end else begin
      load_div_s = div_int;
    end
  end

  // Period counter and fractional accumulator; restart overrides enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
      acc_r <= '0;
      c_r   <= 1'b0;
    end else if (restart) begin
      cnt_r <= '0;
      acc_r <= '0;
      c_r   <= 1'b0;
    end else if (en) begin
      if (tick_os_s) begin
        cnt_r        <= '0;
        {c_r, acc_r} <= sum_s;
      end else begin
        cnt_r <= cnt_r + DIV_W'(1);
      end
    end
  end

  // Active/pending divisors: a same-cycle load re-arms pend after an apply.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r   <= DIV_RST;
      frac_r  <= FRAC_RST;
      pdiv_r  <= DIV_RST;
      pfrac_r <= FRAC_RST;
      pend_r  <= 1'b0;
    end else begin
      if (apply_s) begin
        div_r  <= pdiv_r;
        frac_r <= pfrac_r;
      end
      if (div_load) begin
        pdiv_r  <= load_div_s;
        pfrac_r <= div_frac;
        pend_r  <= 1'b1;
      end else if (apply_s) begin
        pend_r <= 1'b0;
      end
    end
  end

  os_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_os_counter (
    .clk   (clk),
    .reset (reset),
    .en    (tick_os_s),
    .clr   (restart),
    .wrap  (wrap_s)
  );

  assign tick_os  = tick_os_s;
  assign tick_bit = tick_os_s & wrap_s;
  assign q        = cnt_r;
  assign pend     = pend_r;

endmodule

// File: tb/tb_baud_frac_gen.sv
// Scoreboard bench for baud_frac_gen: stimulus queues expected tick gaps and
// bit flags, a negedge monitor measures every tick_os and compares.
module tb_baud_frac_gen;

  localparam int DIV_W = 16;
  localparam int FRAC_W = 4;
  localparam int OS = 4;

  logic              clk;
  logic              reset;
  logic              en;
  logic              restart;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              pend;
  logic              tick_os;
  logic              tick_bit;
  logic [DIV_W-1:0]  q;

  typedef struct {
    int   gap;
    logic tbit;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   os_idx = 0;
  int   gap = 0;

  baud_frac_gen #(
    .DIV_W        (DIV_W),
    .FRAC_W       (FRAC_W),
    .OVERSAMPLE   (OS),
    .DEFAULT_DIV  (4),
    .DEFAULT_FRAC (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .restart  (restart),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .pend     (pend),
    .tick_os  (tick_os),
    .tick_bit (tick_bit),
    .q        (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Monitor: counts enabled cycles since the last boundary and checks each tick.
  always @(negedge clk) begin
    checks++;
    if ((tick_os && (!reset || !en || restart)) || (tick_bit && !tick_os)) begin
      errors++;
      $display("FAIL idle_tick tick_os=%0b tick_bit=%0b en=%0b restart=%0b reset=%0b",
               tick_os, tick_bit, en, restart, reset);
    end
    if (!reset || restart) begin
      gap = 0;
    end else if (en) begin
      gap++;
      if (tick_os) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick gap=%0d want=none", gap);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (gap != e.gap || tick_bit !== e.tbit) begin
            errors++;
            $display("FAIL tick gap=%0d want=%0d tick_bit=%0b want=%0b",
                     gap, e.gap, tick_bit, e.tbit);
          end
        end
        gap = 0;
      end
    end
  end

  task automatic exp_tick(input int g);
    exp_t e;
    e.gap  = g;
    e.tbit = ((os_idx % OS) == OS - 1);
    os_idx++;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_idle(input int d, input int f);
    en       = 1'b0;
    restart  = 1'b0;
    div_load = 1'b1;
    div_int  = DIV_W'(d);
    div_frac = FRAC_W'(f);
    step();
    div_load = 1'b0;
    step();
    #1 chk("apply_idle_pend", 32'(pend), 32'd0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    en      = 1'b1;
    os_idx  = 0;
  endtask

  task automatic end_test(input string name);
    en = 1'b0;
    #1 chk(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic load(input int d);
    div_load = 1'b1;
    div_int  = DIV_W'(d);
    div_frac = 4'd0;
    step();
    div_load = 1'b0;
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    en       = 1'b0;
    restart  = 1'b0;
    div_int  = 16'd0;
    div_frac = 4'd0;
    div_load = 1'b0;
    run(3);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_tick_os", 32'(tick_os), 32'd0);
    chk("rst_tick_bit", 32'(tick_bit), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);

    // T1: default div 4, frac 0
    for (int i = 0; i < 8; i++) exp_tick(4);
    reset = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("t1_q", 32'(q), 32'(i % 4));
      step();
    end
    end_test("t1_drain");

    // T2: div 4 frac 8/16 -> 4,4,5,4,5,... ; 32 periods in 143 cycles
    apply_idle(4, 8);
    do_restart();
    for (int i = 0; i < 32; i++) exp_tick((i < 2) ? 4 : ((i % 2 == 0) ? 5 : 4));
    run(143);
    chk("t2_q_at_143", 32'(q), 32'd0);
    end_test("t2_drain");

    // T3: load 6 at cnt==1 while div 4 is active
    apply_idle(4, 0);
    do_restart();
    exp_tick(4); exp_tick(6); exp_tick(6);
    step();
    load(6);
    chk("t3_pend_set", 32'(pend), 32'd1);
    run(2);
    chk("t3_pend_clr", 32'(pend), 32'd0);
    chk("t3_q_boundary", 32'(q), 32'd0);
    run(12);
    end_test("t3_drain");

    // T4: load 6 on a boundary cycle, then load 0 -> 1-cycle periods
    apply_idle(4, 0);
    do_restart();
    exp_tick(4); exp_tick(4); exp_tick(6); exp_tick(6); exp_tick(6);
    for (int i = 0; i < 4; i++) exp_tick(1);
    run(3);
    #1 chk("t4_tick_at_load", 32'(tick_os), 32'd1);
    load(6);
    chk("t4_pend_waits", 32'(pend), 32'd1);
    run(4);
    chk("t4_pend_applied", 32'(pend), 32'd0);
    run(12);
    load(0);
    chk("t4_pend_zero", 32'(pend), 32'd1);
    run(5);
    chk("t4_pend_zero_clr", 32'(pend), 32'd0);
    run(4);
    end_test("t4_drain");

    // T5: en low at cnt==2, then restart at cnt==2
    apply_idle(4, 0);
    do_restart();
    run(2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_q", 32'(q), 32'd2);
    end
    exp_tick(4);
    en = 1'b1;
    #1 chk("t5_no_tick_yet", 32'(tick_os), 32'd0);
    step();
    chk("t5_tick_after_en", 32'(tick_os), 32'd1);
    step();
    run(2);
    do_restart();
    chk("t5_restart_q", 32'(q), 32'd0);
    for (int i = 0; i < 4; i++) exp_tick(4);
    run(16);
    end_test("t5_drain");

    // T5b: restart on a boundary cycle suppresses the tick and clears acc
    apply_idle(4, 8);
    do_restart();
    exp_tick(4);
    run(7);
    restart = 1'b1;
    #1 chk("t5b_tick_suppressed", 32'(tick_os), 32'd0);
    step();
    restart = 1'b0;
    os_idx  = 0;
    exp_tick(4); exp_tick(4); exp_tick(5);
    run(13);
    end_test("t5b_drain");

    // T6: async reset mid-period with a pending div 9
    apply_idle(5, 0);
    do_restart();
    run(2);
    load(9);
    chk("t6_pend_set", 32'(pend), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_q", 32'(q), 32'd0);
    chk("t6_rst_tick_os", 32'(tick_os), 32'd0);
    chk("t6_rst_tick_bit", 32'(tick_bit), 32'd0);
    chk("t6_rst_pend", 32'(pend), 32'd0);
    step();
    reset  = 1'b1;
    os_idx = 0;
    exp_tick(4); exp_tick(4);
    run(8);
    chk("t6_q_boundary", 32'(q), 32'd0);
    end_test("t6_drain");

    run(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
